// File: rtl/ddr_serializer_if.sv
// Parallel word input handshake and per-lane DDR pair outputs of ddr_serializer.
// The master drives words in; the slave (the serializer) drives the wire side.
interface ddr_serializer_if #(
   parameter int unsigned CHANNELS   = 3,
   parameter int unsigned WORD_WIDTH = 10
);
   logic [CHANNELS*WORD_WIDTH-1:0] in_data;
   logic                           in_valid;
   logic                           in_ready;
   logic [2*CHANNELS-1:0]          twice;
   logic                           word_start;
   logic                           underrun;

   modport master (
      output in_data, in_valid,
      input  in_ready, twice, word_start, underrun
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, twice, word_start, underrun
   );
endinterface

// File: rtl/ddr_serializer.sv
// Multi-lane word-to-pair serializer feeding DDR output cells, with a one-word
// holding buffer, idle fill, selectable bit order and underrun reporting.
module ddr_serializer #(
   parameter int unsigned            CHANNELS   = 3,
   parameter int unsigned            WORD_WIDTH = 10,
   parameter logic [WORD_WIDTH-1:0]  IDLE_WORD  = '0,
   parameter bit                     LSB_FIRST  = 1'b1
) (
   input logic              clock,
   input logic              reset,
   ddr_serializer_if.slave  bus_io
);

   localparam int unsigned Beats = WORD_WIDTH / 2;
   localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

   if ((WORD_WIDTH % 2) != 0 || WORD_WIDTH < 4) begin : gen_bad_width
      $error("ddr_serializer: WORD_WIDTH must be even and at least 4");
   end

   logic [CntW-1:0]                beat_q, beat_d;
   logic [CHANNELS*WORD_WIDTH-1:0] hold_q, hold_d;
   logic                           hold_valid_q, hold_valid_d;
   logic                           primed_q, primed_d;
   logic                           underrun_q, underrun_d;
   logic [WORD_WIDTH-1:0]          sr_q [CHANNELS];
   logic [WORD_WIDTH-1:0]          sr_d [CHANNELS];

   logic load;
   logic ready;
   logic accept;

   always_comb begin
      load   = (beat_q == LastBeat);
      ready  = !hold_valid_q || load;
      accept = bus_io.in_valid && ready;
   end

   always_comb begin
      beat_d       = load ? '0 : beat_q + 1'b1;
      hold_d       = accept ? bus_io.in_data : hold_q;
      primed_d     = primed_q || accept;
      // On a load edge hold drains into sr, so it stays full only if refilled now.
      hold_valid_d = accept ? 1'b1 : (load ? 1'b0 : hold_valid_q);
      underrun_d   = load && !hold_valid_q && primed_q;
      for (int c = 0; c < CHANNELS; c++) begin
         if (load) begin
            sr_d[c] = hold_valid_q ? hold_q[c*WORD_WIDTH +: WORD_WIDTH] : IDLE_WORD;
         end else if (LSB_FIRST) begin
            sr_d[c] = sr_q[c] >> 2;
         end else begin
            sr_d[c] = sr_q[c] << 2;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         beat_q       <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         primed_q     <= 1'b0;
         underrun_q   <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            sr_q[c] <= IDLE_WORD;
         end
      end else begin
         beat_q       <= beat_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         primed_q     <= primed_d;
         underrun_q   <= underrun_d;
         for (int c = 0; c < CHANNELS; c++) begin
            sr_q[c] <= sr_d[c];
         end
      end
   end

   always_comb begin
      bus_io.in_ready   = ready;
      bus_io.word_start = (beat_q == '0);
      bus_io.underrun   = underrun_q;
      bus_io.twice      = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         // Bit 2c is D0, the half that leaves the DDR cell first.
         if (LSB_FIRST) begin
            bus_io.twice[2*c]   = sr_q[c][0];
            bus_io.twice[2*c+1] = sr_q[c][1];
         end else begin
            bus_io.twice[2*c]   = sr_q[c][WORD_WIDTH-1];
            bus_io.twice[2*c+1] = sr_q[c][WORD_WIDTH-2];
         end
      end
   end

endmodule

// File: tb/tb_ddr_serializer.sv
// Directed bench for ddr_serializer: three instances cover LSB-first, MSB-first
// and a three-lane gapless stream.
module tb_ddr_serializer;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   ddr_serializer_if #(.CHANNELS(1), .WORD_WIDTH(10)) if_a ();
   ddr_serializer_if #(.CHANNELS(1), .WORD_WIDTH(10)) if_b ();
   ddr_serializer_if #(.CHANNELS(3), .WORD_WIDTH(10)) if_c ();

   ddr_serializer #(
      .CHANNELS(1), .WORD_WIDTH(10), .IDLE_WORD(10'h155), .LSB_FIRST(1'b1)
   ) dut_a (
      .clock  (clock),
      .reset  (reset),
      .bus_io (if_a)
   );

   ddr_serializer #(
      .CHANNELS(1), .WORD_WIDTH(10), .IDLE_WORD(10'h155), .LSB_FIRST(1'b0)
   ) dut_b (
      .clock  (clock),
      .reset  (reset),
      .bus_io (if_b)
   );

   ddr_serializer #(
      .CHANNELS(3), .WORD_WIDTH(10), .IDLE_WORD(10'h000), .LSB_FIRST(1'b1)
   ) dut_c (
      .clock  (clock),
      .reset  (reset),
      .bus_io (if_c)
   );

   function automatic logic [29:0] pack3(input int n);
      logic [29:0] r;
      for (int c = 0; c < 3; c++) r[c*10 +: 10] = 10'(n + 64 * c);
      return r;
   endfunction

   function automatic logic [1:0] pair_of(input logic [9:0] w, input int j);
      logic [9:0] s;
      s = w >> (2 * j);
      return s[1:0];
   endfunction

   // Leaves the bench at the negedge where reset drops; that cycle has b == 0.
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      if_a.in_valid = 1'b0;
      if_b.in_valid = 1'b0;
      if_c.in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1;
      if_a.in_valid = 1'b0;
      if_b.in_valid = 1'b0;
      if_c.in_valid = 1'b0;
      #1;
      checks++;
      if (if_a.twice !== 2'b01 || if_a.word_start !== 1'b1 || if_a.in_ready !== 1'b1 ||
          if_a.underrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_a got twice=%b ws=%b rdy=%b ur=%b want 01 1 1 0",
                  if_a.twice, if_a.word_start, if_a.in_ready, if_a.underrun);
      end
      checks++;
      if (if_b.twice !== 2'b10) begin
         errors++;
         $display("FAIL reset_b_twice got %b want 10", if_b.twice);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clock);
         checks++;
         if (if_a.twice !== 2'b01 || if_a.word_start !== (k % 5 == 0) ||
             if_a.underrun !== 1'b0 || if_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle k=%0d got twice=%b ws=%b ur=%b rdy=%b want 01 %b 0 1",
                     k, if_a.twice, if_a.word_start, if_a.underrun, if_a.in_ready,
                     (k % 5 == 0));
         end
      end
   endtask

   task automatic test_single_lsb();
      logic [1:0] exp_pairs [5] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b11};
      logic [1:0] exp_tw;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clock);
         exp_tw = (k >= 5 && k <= 9) ? exp_pairs[k-5] : 2'b01;
         checks++;
         if (if_a.twice !== exp_tw || if_a.word_start !== (k % 5 == 0) ||
             if_a.underrun !== (k == 10) || if_a.in_ready !== !(k >= 1 && k <= 3)) begin
            errors++;
            $display("FAIL single_lsb k=%0d got twice=%b ws=%b ur=%b rdy=%b want %b %b %b %b",
                     k, if_a.twice, if_a.word_start, if_a.underrun, if_a.in_ready,
                     exp_tw, (k % 5 == 0), (k == 10), !(k >= 1 && k <= 3));
         end
         if_a.in_valid = (k == 0);
         if_a.in_data  = 10'h365;
      end
      if_a.in_valid = 1'b0;
   endtask

   task automatic test_single_msb();
      logic [1:0] exp_pairs [5] = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b10};
      logic [1:0] exp_tw;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clock);
         exp_tw = (k >= 5 && k <= 9) ? exp_pairs[k-5] : 2'b10;
         checks++;
         if (if_b.twice !== exp_tw || if_b.underrun !== (k == 10)) begin
            errors++;
            $display("FAIL single_msb k=%0d got twice=%b ur=%b want %b %b",
                     k, if_b.twice, if_b.underrun, exp_tw, (k == 10));
         end
         if_b.in_valid = (k == 0);
         if_b.in_data  = 10'h365;
      end
      if_b.in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int         nxt;
      logic       acc_prev;
      logic       exp_rdy;
      logic [5:0] exp_tw;
      logic [9:0] lane_w;
      nxt      = 1;
      acc_prev = 1'b0;
      do_reset();
      for (int k = 0; k < 45; k++) begin
         if (k > 0) @(negedge clock);
         exp_rdy = (k == 0) || (k % 5 == 4);
         for (int c = 0; c < 3; c++) begin
            lane_w = 10'((k / 5) + 64 * c);
            exp_tw[2*c +: 2] = (k < 5) ? 2'b00 : pair_of(lane_w, k % 5);
         end
         checks++;
         if (if_c.twice !== exp_tw || if_c.in_ready !== exp_rdy || if_c.underrun !== 1'b0 ||
             if_c.word_start !== (k % 5 == 0)) begin
            errors++;
            $display("FAIL gapless k=%0d got twice=%h rdy=%b ur=%b ws=%b want %h %b 0 %b",
                     k, if_c.twice, if_c.in_ready, if_c.underrun, if_c.word_start,
                     exp_tw, exp_rdy, (k % 5 == 0));
         end
         if (acc_prev) nxt++;
         if_c.in_valid = 1'b1;
         if_c.in_data  = pack3(nxt);
         acc_prev      = exp_rdy;
      end
      if_c.in_valid = 1'b0;
   endtask

   task automatic test_back_pressure();
      logic [9:0] wx;
      logic [9:0] wy;
      logic [1:0] exp_tw;
      logic       exp_rdy;
      wx = 10'h2A3;
      wy = 10'h1CE;
      do_reset();
      for (int k = 0; k < 17; k++) begin
         if (k > 0) @(negedge clock);
         exp_rdy = !((k >= 1 && k <= 3) || (k >= 5 && k <= 8));
         if (k >= 5 && k <= 9)        exp_tw = pair_of(wx, k - 5);
         else if (k >= 10 && k <= 14) exp_tw = pair_of(wy, k - 10);
         else                         exp_tw = 2'b01;
         checks++;
         if (if_a.twice !== exp_tw || if_a.in_ready !== exp_rdy ||
             if_a.underrun !== (k == 15)) begin
            errors++;
            $display("FAIL back_pressure k=%0d got twice=%b rdy=%b ur=%b want %b %b %b",
                     k, if_a.twice, if_a.in_ready, if_a.underrun, exp_tw, exp_rdy, (k == 15));
         end
         if_a.in_valid = (k <= 4);
         if_a.in_data  = (k == 0) ? wx : wy;
      end
      if_a.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clock);
         if_a.in_valid = (k <= 4);
         if_a.in_data  = (k == 0) ? 10'h3FF : 10'h2AA;
      end
      // k == 7: b == 2 with 10'h3FF on the wire and 10'h2AA waiting in hold.
      checks++;
      if (if_a.twice !== 2'b11) begin
         errors++;
         $display("FAIL mid_word_pre got %b want 11", if_a.twice);
      end
      reset = 1'b1;
      if_a.in_valid = 1'b0;
      #1;
      checks++;
      if (if_a.twice !== 2'b01 || if_a.word_start !== 1'b1 || if_a.in_ready !== 1'b1 ||
          if_a.underrun !== 1'b0) begin
         errors++;
         $display("FAIL mid_word_reset got twice=%b ws=%b rdy=%b ur=%b want 01 1 1 0",
                  if_a.twice, if_a.word_start, if_a.in_ready, if_a.underrun);
      end
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clock);
         checks++;
         if (if_a.twice !== 2'b01 || if_a.underrun !== 1'b0 ||
             if_a.word_start !== (k % 5 == 0)) begin
            errors++;
            $display("FAIL mid_word_after k=%0d got twice=%b ur=%b ws=%b want 01 0 %b",
                     k, if_a.twice, if_a.underrun, if_a.word_start, (k % 5 == 0));
         end
      end
   endtask

   initial begin
      if_a.in_valid = 1'b0;
      if_a.in_data  = '0;
      if_b.in_valid = 1'b0;
      if_b.in_data  = '0;
      if_c.in_valid = 1'b0;
      if_c.in_data  = '0;
      test_reset();
      test_single_lsb();
      test_single_msb();
      test_back_to_back();
      test_back_pressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
